// File: rtl/hdmi_video_pkg.sv
// Shared types and default 720p60 timing for the HDMI raster generator.
// Also holds the colour-bar table used when HDMI_VIDEO_TIMING_GEN_TEST_PATTERN_EN is defined.
package hdmi_video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int unsigned H_ACTIVE_720P = 1280;
  localparam int unsigned H_FP_720P     = 110;
  localparam int unsigned H_SYNC_720P   = 40;
  localparam int unsigned H_BP_720P     = 220;
  localparam int unsigned V_ACTIVE_720P = 720;
  localparam int unsigned V_FP_720P     = 5;
  localparam int unsigned V_SYNC_720P   = 5;
  localparam int unsigned V_BP_720P     = 20;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/hdmi_video_timing_counter.sv
// Raster h/v counters with region decode and wrap flags.
// Adds the colour-bar comparator chain when HDMI_VIDEO_TIMING_GEN_TEST_PATTERN_EN is defined.
module hdmi_video_timing_counter
  import hdmi_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
  parameter int unsigned H_FP     = H_FP_720P,
  parameter int unsigned H_SYNC   = H_SYNC_720P,
  parameter int unsigned H_BP     = H_BP_720P,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
  parameter int unsigned V_FP     = V_FP_720P,
  parameter int unsigned V_SYNC   = V_SYNC_720P,
  parameter int unsigned V_BP     = V_BP_720P
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       active,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       origin,
  output logic       frame_end
`ifdef HDMI_VIDEO_TIMING_GEN_TEST_PATTERN_EN
  ,output logic [2:0] bar_idx
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          line_end;

  always_comb begin
    line_end  = 32'(h_cnt_q) == H_TOTAL - 1;
    frame_end = line_end && (32'(v_cnt_q) == V_TOTAL - 1);
    h_cnt_d   = '0;
    v_cnt_d   = '0;
    if (run) begin
      h_cnt_d = line_end ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (line_end) v_cnt_d = frame_end ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
  assign hs_raw = (32'(h_cnt_q) >= H_ACTIVE + H_FP) && (32'(h_cnt_q) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw = (32'(v_cnt_q) >= V_ACTIVE + V_FP) && (32'(v_cnt_q) < V_ACTIVE + V_FP + V_SYNC);
  assign origin = (h_cnt_q == '0) && (v_cnt_q == '0);

`ifdef HDMI_VIDEO_TIMING_GEN_TEST_PATTERN_EN
  // Bar k starts at ceil(k*H_ACTIVE/8); the chain of compares replaces h*8/H_ACTIVE.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++)
      if (32'(h_cnt_q) >= (32'(k) * H_ACTIVE + 7) / 8) bar_idx = 3'(k);
  end
`endif

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// HDMI raster timing generator with 1-cycle FIFO pixel fetch and sticky underflow.
// Optional colour-bar source under HDMI_VIDEO_TIMING_GEN_TEST_PATTERN_EN.
module hdmi_video_timing_gen
  import hdmi_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
  parameter int unsigned H_FP     = H_FP_720P,
  parameter int unsigned H_SYNC   = H_SYNC_720P,
  parameter int unsigned H_BP     = H_BP_720P,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
  parameter int unsigned V_FP     = V_FP_720P,
  parameter int unsigned V_SYNC   = V_SYNC_720P,
  parameter int unsigned V_BP     = V_BP_720P,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        pixe_clk,
  input  logic        rest_n,
  input  logic        enable,
  output logic        pix_req,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr
`ifdef HDMI_VIDEO_TIMING_GEN_TEST_PATTERN_EN
  ,input  logic        test_pattern
`endif
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam logic       SYNC_IDLE = !SYNC_POL;

  logic [0:0] state_q, state_d;
  logic       run, active, hs_raw, vs_raw, origin, frame_end;
  logic       de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic       fs_q, fs_d, uf_q, uf_d;
  logic       tp_now, tp_q;
  rgb888_t    tp_rgb, pix_rgb;

`ifdef HDMI_VIDEO_TIMING_GEN_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  logic       tp_sel_q, tp_sel_d;
  rgb888_t    tp_rgb_q, tp_rgb_d;
`endif

  hdmi_video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .clk      (pixe_clk),
    .rst_n    (rest_n),
    .run      (run),
    .active   (active),
    .hs_raw   (hs_raw),
    .vs_raw   (vs_raw),
    .origin   (origin),
    .frame_end(frame_end)
`ifdef HDMI_VIDEO_TIMING_GEN_TEST_PATTERN_EN
    ,.bar_idx (bar_idx)
`endif
  );

  assign run = state_q == ST_RUN;

`ifdef HDMI_VIDEO_TIMING_GEN_TEST_PATTERN_EN
  // Mode is latched at raster origin so a frame is never half pattern, half FIFO.
  assign tp_now = origin ? test_pattern : tp_sel_q;
  assign tp_q   = tp_sel_q;
  assign tp_rgb = tp_rgb_q;

  always_comb begin
    tp_sel_d = tp_now;
    tp_rgb_d = (run && active) ? rgb888_t'(BAR_RGB[bar_idx]) : '0;
  end

  always_ff @(posedge pixe_clk or negedge rest_n) begin
    if (!rest_n) begin
      tp_sel_q <= 1'b0;
      tp_rgb_q <= '0;
    end else begin
      tp_sel_q <= tp_sel_d;
      tp_rgb_q <= tp_rgb_d;
    end
  end
`else
  assign tp_now = 1'b0;
  assign tp_q   = 1'b0;
  assign tp_rgb = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      default: if (frame_end && !enable) state_d = ST_IDLE;
    endcase
  end

  assign pix_req = run && active && !tp_now;

  always_comb begin
    de_d    = run && active;
    hsync_d = (run && hs_raw) ^ SYNC_IDLE;
    vsync_d = (run && vs_raw) ^ SYNC_IDLE;
    fs_d    = run && origin;
    uf_d    = (de_q && !pix_valid && !tp_q) || (uf_q && !underflow_clr);
  end

  always_ff @(posedge pixe_clk or negedge rest_n) begin
    if (!rest_n) begin
      state_q <= ST_IDLE;
      de_q    <= 1'b0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  // FIFO data lands in the same cycle as de, so the colour mux sits after the de flop.
  always_comb begin
    pix_rgb = '0;
    if (de_q) begin
      if (tp_q)           pix_rgb = tp_rgb;
      else if (pix_valid) pix_rgb = rgb888_t'(pix_data);
    end
  end

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign red         = pix_rgb.r;
  assign green       = pix_rgb.g;
  assign blue        = pix_rgb.b;

endmodule

// File: doc/hdmi_video_timing_gen.md
Name: hdmi_video_timing_gen

Overview:
- Raster timing generator and pixel fetch stage directly upstream of the HDMI TMDS encoder/serializer.
- Produces hsync/vsync/de plus 8-bit red/green/blue in the pixe_clk domain.
- Pulls pixels from the frame-buffer read FIFO with a 1-cycle-latency request/valid handshake.
- Starts and stops only on frame boundaries; flags FIFO underflow.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low

Ports:
- pixe_clk  in  1  pixel clock
- rest_n  in  1  asynchronous active-low reset
- enable  in  1  run request; sampled only at frame boundary
- pix_req  out  1  FIFO read strobe; data is expected on the following cycle
- pix_valid  in  1  FIFO data valid, one cycle after pix_req
- pix_data  in  24  {R[23:16], G[15:8], B[7:0]}
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable
- red  out  8  pixel red
- green  out  8  pixel green
- blue  out  8  pixel blue
- frame_start  out  1  1-cycle pulse on the first pixe_clk of each frame (h=0, v=0) while RUN
- underflow  out  1  sticky underflow flag
- underflow_clr  in  1  clears underflow

Behaviour:
- Reset (async, rest_n=0): state IDLE, counters 0. Outputs: pix_req=0, de=0, RGB=0, frame_start=0, underflow=0, hsync/vsync=inactive level (0 if SYNC_POL=1, else 1).
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; widths are $clog2 of the totals.
  - h_cnt increments every cycle in RUN and wraps H_TOTAL-1 -> 0.
  - v_cnt increments on each h wrap and wraps V_TOTAL-1 -> 0.
- Regions (h_cnt/v_cnt is the current raster position; outputs are registered and appear one cycle later):
  - Active: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hsync asserted while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, evaluated per whole line.
- Pipeline:
  - pix_req = combinational active(h_cnt, v_cnt) while in RUN.
  - hsync/vsync/de/RGB are registered, so de rises exactly one cycle after the first pix_req of a line, coincident with pix_valid.
  - Latency from raster position to outputs: 1 cycle.
- Data path:
  - de_out=1 and pix_valid=1: RGB = pix_data fields.
  - de_out=1 and pix_valid=0: RGB = 0 (black) and underflow set.
  - de_out=0: RGB = 0.
  - underflow is cleared by underflow_clr. If set and clear occur in the same cycle, set wins.
- FSM:
  - IDLE: counters held at 0, syncs inactive, pix_req=0. Moves to RUN when enable=1.
  - RUN: free-running raster. At frame end (h=H_TOTAL-1, v=V_TOTAL-1), if enable=0, go to IDLE with counters reset to 0; otherwise wrap and continue.
  - enable dropping mid-frame has no effect until frame end, so no partial frames are emitted.
- frame_start is registered: it asserts the cycle after the counters equal 0/0 in RUN, aligned with the first de.
- Sync outputs are inverted when SYNC_POL=0.

Optional Feature:
- Macro: HDMI_VIDEO_TIMING_GEN_TEST_PATTERN_EN.
- Defined:
  - Adds input test_pattern (1 bit).
  - When test_pattern=1: pix_req forced 0, underflow never sets, and active pixels show 8 vertical colour bars. Bar index = h_cnt*8/H_ACTIVE, computed with a stage-registered comparator chain (no divider). Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black, each channel 8'hFF or 8'h00.
  - test_pattern is sampled only at frame start.
- Undefined: port absent; behaviour as above.

Decomposition:
- Package hdmi_video_pkg holds:
  - typedef rgb888_t (packed struct r, g, b).
  - Default 720p timing localparams.
  - Colour-bar constant array.
- One sub-module, hdmi_video_timing_counter: h/v counters, region decode and wrap flags.
- Top level holds the FSM, data-path registers, underflow logic and the optional pattern.

Test Plan:
- Reset with enable=1 released: first frame_start exactly 1 cycle after RUN is entered. Check de high for 1280 cycles per line over 720 lines, hsync width 40 beginning 110 clocks after de falls, and vsync 5 lines starting at line 725.
- Small parameters (H 8/2/2/2, V 4/1/1/1) with FIFO model returning an incrementing pattern: RGB equals the request order and count per frame is 32. Check pix_req leads de by exactly 1 cycle.
- Withhold pix_valid for 3 cycles mid-line: RGB=0 for those cycles and underflow=1 until underflow_clr. Assert set and clear in the same cycle: flag stays 1.
- Drop enable at mid-frame: the frame completes (V_TOTAL*H_TOTAL cycles from frame_start), then IDLE with no pix_req. Re-assert enable: new frame_start.
- Assert rest_n mid-line: all outputs reach their reset values asynchronously with no clock edge. SYNC_POL=0: hsync/vsync idle high and pulse low.
- With the macro defined and test_pattern=1: the first pixel is FFFFFF, pixel H_ACTIVE/8 is FFFF00, the last bar is 000000, and pix_req stays 0.
